// File: rtl/mem_seq.sv
// Fill-then-scan memory sequencer: writes SEED+addr to 32 words, reads them back and counts mismatches.
// Optional checker (comparator and error counter) is built only when MEM_SEQ_CHECK_EN is defined.
module mem_seq #(
    parameter logic [31:0] SEED = 32'hA5A5_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        we,
    output logic [4:0]  wadr,
    output logic [31:0] wd,
    output logic [4:0]  radr,
    input  logic [31:0] rd,
    output logic [5:0]  err_cnt,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, FILL, SCAN, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  adr_q, adr_d;
    logic [31:0] exp_data;

    // Same pattern word is written in FILL and expected back in SCAN.
    assign exp_data = SEED + {27'b0, adr_q};

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        busy    = 1'b0;
        done    = 1'b0;
        we      = 1'b0;
        wadr    = 5'd0;
        wd      = 32'd0;
        radr    = 5'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    adr_d   = 5'd0;
                    state_d = FILL;
                end
            end
            FILL: begin
                busy  = 1'b1;
                we    = 1'b1;
                wadr  = adr_q;
                wd    = exp_data;
                adr_d = adr_q + 5'd1;
                if (adr_q == 5'd31) state_d = SCAN;
            end
            SCAN: begin
                busy  = 1'b1;
                radr  = adr_q;
                adr_d = adr_q + 5'd1;
                if (adr_q == 5'd31) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            adr_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
        end
    end

`ifdef MEM_SEQ_CHECK_EN
    logic [5:0] err_cnt_q, err_cnt_d;

    // Saturates at 32, the most mismatches a single pass can produce.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == IDLE && start)
            err_cnt_d = 6'd0;
        else if (state_q == SCAN && rd != exp_data && err_cnt_q != 6'd32)
            err_cnt_d = err_cnt_q + 6'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_cnt_q <= 6'd0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
    assign err     = |err_cnt_q;
`else
    logic unused_rd;
    assign unused_rd = ^rd;
    assign err_cnt   = 6'd0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_seq.sv
// Randomized bench for mem_seq: a cycle-count model of a pass predicts every output each cycle.
module tb_mem_seq;
    localparam logic [31:0] SEED_T = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, we, err;
    logic [4:0]  wadr, radr;
    logic [31:0] wd, rd;
    logic [5:0]  err_cnt;

    mem_seq #(.SEED(SEED_T)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .we(we), .wadr(wadr), .wd(wd), .radr(radr), .rd(rd),
        .err_cnt(err_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Memory model with controllable read corruption.
    logic [31:0] mem [32];
    int          mode = 0;
    logic [31:0] mask = 32'h0;
    logic [31:0] flip = 32'h1;

    always @(posedge clk) if (we) mem[wadr] <= wd;
    assign rd = (mode == 2) ? 32'h0 : (mem[radr] ^ (mask[radr] ? flip : 32'h0));

    function automatic bit bad(input int w);
        if (mode == 2) return (SEED_T + 32'(w)) != 32'h0;
        return mask[w];
    endfunction

    // k = cycles elapsed since the accepted start edge (0 = idle); m_err = mismatches so far.
    int k = 0;
    int m_err = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k     <= 0;
            m_err <= 0;
        end else if (k == 0) begin
            if (start) begin
                k     <= 1;
                m_err <= 0;
            end
        end else begin
            if (k >= 33 && k <= 64 && bad(k - 33) && m_err < 32) m_err <= m_err + 1;
            k <= (k == 65) ? 0 : k + 1;
        end
    end

    always @(negedge clk) begin
        logic        e_busy, e_done, e_we, e_err;
        logic [4:0]  e_wadr, e_radr;
        logic [31:0] e_wd;
        logic [5:0]  e_cnt;
        e_busy = (k >= 1 && k <= 64);
        e_we   = (k >= 1 && k <= 32);
        e_wadr = e_we ? 5'(k - 1) : 5'd0;
        e_wd   = e_we ? SEED_T + 32'(k - 1) : 32'h0;
        e_radr = (k >= 33 && k <= 64) ? 5'(k - 33) : 5'd0;
        e_done = (k == 65);
`ifdef MEM_SEQ_CHECK_EN
        e_cnt = 6'(m_err);
`else
        e_cnt = 6'd0;
`endif
        e_err = (e_cnt != 6'd0);
        check("cycle_outputs", {busy, done, we, wadr, wd, radr, err_cnt, err},
              {e_busy, e_done, e_we, e_wadr, e_wd, e_radr, e_cnt, e_err});
    end

    task automatic run_pass(input int restart_at, input int reset_at,
                            output int done_at, output int busy_n, output int n_done,
                            output logic [31:0] wd1, output logic [31:0] wd32,
                            output logic [4:0] wadr32, output logic [5:0] ec1,
                            output logic [5:0] ec_done);
        @(negedge clk);
        start   = 1'b1;
        done_at = 0;
        busy_n  = 0;
        n_done  = 0;
        ec_done = 6'h3f;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            start = (i == restart_at);
            if (busy) busy_n++;
            if (done) begin
                n_done++;
                done_at = i;
                ec_done = err_cnt;
            end
            if (i == 1) begin
                wd1 = wd;
                ec1 = err_cnt;
            end
            if (i == 32) begin
                wd32   = wd;
                wadr32 = wadr;
            end
            if (reset_at != 0 && i == reset_at) begin
                #2 reset = 1'b1;
                #1 check("reset_async", {busy, done, we, wadr, wd, radr, err_cnt, err}, 64'h0);
            end
            if (reset_at != 0 && i == reset_at + 3) reset = 1'b0;
        end
    endtask

    int          done_at, busy_n, n_done;
    logic [31:0] wd1, wd32;
    logic [4:0]  wadr32;
    logic [5:0]  ec1, ec_done;
    logic [5:0]  e2, e32, er;

    initial begin
`ifdef MEM_SEQ_CHECK_EN
        e2 = 6'd2; e32 = 6'd32;
`else
        e2 = 6'd0; e32 = 6'd0;
`endif
        #1 reset = 1'b1;
        #1 check("reset_state", {busy, done, we, wadr, wd, radr, err_cnt, err}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Ideal memory pass.
        run_pass(0, 0, done_at, busy_n, n_done, wd1, wd32, wadr32, ec1, ec_done);
        check("ideal_done_latency", 64'(done_at), 64'd65);
        check("ideal_busy_cycles", 64'(busy_n), 64'd64);
        check("ideal_done_pulses", 64'(n_done), 64'd1);
        check("fill_first_wd", wd1, 64'hA5A5_0000);
        check("fill_last_wd", wd32, 64'hA5A5_001F);
        check("fill_last_wadr", wadr32, 64'd31);
        check("ideal_err_cnt", ec_done, 64'd0);

        // Words 3 and 17 corrupted.
        mask = 32'h0002_0008;
        flip = 32'h0000_0100;
        run_pass(0, 0, done_at, busy_n, n_done, wd1, wd32, wadr32, ec1, ec_done);
        check("two_bad_err_cnt", ec_done, e2);
        repeat (5) @(negedge clk);
        check("two_bad_held_cnt", err_cnt, e2);
        check("two_bad_held_err", err, 64'(e2 != 6'd0));

        // Every read returns zero.
        mask = 32'h0;
        mode = 2;
        run_pass(0, 0, done_at, busy_n, n_done, wd1, wd32, wadr32, ec1, ec_done);
        check("clear_on_start", ec1, 64'd0);
        check("all_bad_err_cnt", ec_done, e32);
        mode = 0;

        // Start re-pulsed during SCAN must be ignored.
        run_pass(42, 0, done_at, busy_n, n_done, wd1, wd32, wadr32, ec1, ec_done);
        check("restart_done_pulses", 64'(n_done), 64'd1);
        check("restart_done_latency", 64'(done_at), 64'd65);

        // Asynchronous reset in the middle of FILL.
        run_pass(0, 20, done_at, busy_n, n_done, wd1, wd32, wadr32, ec1, ec_done);
        check("abort_no_done", 64'(n_done), 64'd0);
        run_pass(0, 0, done_at, busy_n, n_done, wd1, wd32, wadr32, ec1, ec_done);
        check("post_abort_done_latency", 64'(done_at), 64'd65);
        check("post_abort_err_cnt", ec_done, 64'd0);

        // Random corruption patterns, stray starts and idle gaps.
        for (int p = 0; p < 10; p++) begin
            mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            mask = $urandom;
            flip = $urandom | 32'h1;
            run_pass($urandom_range(2, 64), 0, done_at, busy_n, n_done, wd1, wd32, wadr32, ec1, ec_done);
`ifdef MEM_SEQ_CHECK_EN
            er = (mode == 2) ? 6'd32 : 6'($countones(mask));
`else
            er = 6'd0;
`endif
            check("rand_done_latency", 64'(done_at), 64'd65);
            check("rand_err_cnt", ec_done, er);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
